// File: rtl/can_destuff_sampler.sv
// CAN receive bit sampler with hard sync, bit destuffing,
// stuff-error detection and bus-idle tracking.
module can_destuff_sampler #(
  parameter int CLKS_PER_BIT = 10,
  parameter int SAMPLE_POINT = 7,
  parameter int STUFF_LEN    = 5,
  parameter int IDLE_BITS    = 11
) (
  input  logic i_Clock,
  input  logic i_Reset_n,
  input  logic i_Rx_Serial,
  input  logic i_Stuff_En,
  output logic o_Sof,
  output logic o_Bit_Valid,
  output logic o_Bit_Data,
  output logic o_Stuff_Bit,
  output logic o_Stuff_Error,
  output logic o_Bus_Idle
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int RW = $clog2(STUFF_LEN + 1);
  localparam int NW = $clog2(IDLE_BITS + 1);

  typedef enum logic [1:0] {
    S_IDLE_WAIT,
    S_IDLE,
    S_RUN
  } state_e;

  state_e state_q, state_d;
  logic sync1_q, sync2_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] run_q, run_d;
  logic [NW-1:0] rec_q, rec_d;
  logic sofp_q, sofp_d;
  logic last_q, last_d;
  logic sof_q, sof_d;
  logic valid_q, valid_d;
  logic data_q, data_d;
  logic stuff_q, stuff_d;
  logic err_q, err_d;
  logic idle_q, idle_d;

  logic fell, strobe, smp, take, body, at_len;
  logic ev_sof, ev_stuff, ev_err, ev_emit;
  logic rec_full;
  logic [NW-1:0] rec_nxt;
  logic [RW-1:0] run_inc;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q <= S_IDLE_WAIT;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      run_q   <= '0;
      rec_q   <= '0;
      sofp_q  <= 1'b0;
      last_q  <= 1'b0;
      sof_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= 1'b0;
      stuff_q <= 1'b0;
      err_q   <= 1'b0;
      idle_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= i_Rx_Serial;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      rec_q   <= rec_d;
      sofp_q  <= sofp_d;
      last_q  <= last_d;
      sof_q   <= sof_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      stuff_q <= stuff_d;
      err_q   <= err_d;
      idle_q  <= idle_d;
    end
  end

  always_comb begin
    fell   = prev_q & ~sync2_q;
    strobe = (cnt_q == CW'(SAMPLE_POINT));
    smp    = sync2_q;
    take   = strobe & (state_q == S_RUN);
    body   = take & ~sofp_q;
    at_len = (run_q == RW'(STUFF_LEN));
    ev_sof   = take & sofp_q & ~smp;
    ev_stuff = body & i_Stuff_En & at_len & (smp != last_q);
    ev_err   = body & i_Stuff_En & at_len & (smp == last_q);
    ev_emit  = body & ~(i_Stuff_En & at_len);
    if (rec_q == NW'(IDLE_BITS)) rec_nxt = rec_q;
    else                         rec_nxt = rec_q + NW'(1);
    if (!smp) rec_nxt = '0;
    rec_full = (rec_nxt == NW'(IDLE_BITS));
    run_inc  = at_len ? run_q : run_q + RW'(1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == CW'(CLKS_PER_BIT - 1)) ? '0 : cnt_q + CW'(1);
    run_d   = run_q;
    rec_d   = rec_q;
    sofp_d  = sofp_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE_WAIT: begin
        if (strobe) begin
          rec_d = rec_nxt;
          if (rec_full) state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        cnt_d = '0;
        if (fell) begin
          // edge cycle counts as bit clock 0
          cnt_d   = CW'(1);
          state_d = S_RUN;
          sofp_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (fell) cnt_d = CW'(1);
        if (strobe) begin
          rec_d = rec_nxt;
          if (sofp_q) begin
            if (smp) begin
              state_d = S_IDLE;
            end else begin
              sofp_d = 1'b0;
              run_d  = RW'(1);
              last_d = 1'b0;
            end
          end else if (ev_err) begin
            state_d = S_IDLE_WAIT;
            rec_d   = '0;
          end else begin
            last_d = smp;
            if (ev_stuff || !i_Stuff_En)
              run_d = RW'(1);
            else
              run_d = (smp == last_q) ? run_inc : RW'(1);
            if (rec_full) state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE_WAIT;
    endcase
  end

  always_comb begin
    sof_d   = ev_sof;
    valid_d = ev_emit;
    stuff_d = ev_stuff;
    data_d  = ev_emit ? smp : data_q;
    idle_d  = (state_d == S_IDLE);
    err_d   = err_q;
    unique case (1'b1)
      ev_sof:  err_d = 1'b0;
      ev_err:  err_d = 1'b1;
      default: err_d = err_q;
    endcase
  end

  assign o_Sof         = sof_q;
  assign o_Bit_Valid   = valid_q;
  assign o_Bit_Data    = data_q;
  assign o_Stuff_Bit   = stuff_q;
  assign o_Stuff_Error = err_q;
  assign o_Bus_Idle    = idle_q;

endmodule

// File: doc/can_destuff_sampler.md
# can_destuff_sampler

Parametrised successor to the CAN bit destuffer: a self-timed bit sampler plus destuffer for a single CAN receive line. It synchronises the raw serial input and hard-syncs bit timing on start-of-frame and on every recessive-to-dominant edge. It samples each bit at a programmable sample point, removes stuff bits with a configurable run length, and flags stuff errors. It tracks bus-idle so the downstream receive state machine gets a clean destuffed bit stream with SOF and error markers.

## Interface
- CLKS_PER_BIT, 10, clocks per nominal bit time (>=4)
- SAMPLE_POINT, 7, clock index within the bit at which the line is sampled (1..CLKS_PER_BIT-2)
- STUFF_LEN, 5, identical consecutive bits after which a complementary stuff bit is expected (>=2)
- IDLE_BITS, 11, consecutive recessive samples that declare the bus idle
- i_Clock  in  1  single system clock, rising edge
- i_Reset_n  in  1  asynchronous, active-low reset
- i_Rx_Serial  in  1  raw CAN RX line (1 = recessive)
- i_Stuff_En  in  1  1 = destuffing active (SOF..CRC), 0 = pass every bit (CRC delimiter onward)
- o_Sof  out  1  one-cycle pulse when the SOF bit is sampled
- o_Bit_Valid  out  1  one-cycle pulse per destuffed data bit
- o_Bit_Data  out  1  value of the bit; meaningful only with o_Bit_Valid
- o_Stuff_Bit  out  1  one-cycle pulse when a stuff bit is discarded
- o_Stuff_Error  out  1  sticky stuff-error flag; cleared at next SOF or reset
- o_Bus_Idle  out  1  level, 1 while in IDLE state

## Operation
- Input: 2-flop synchroniser, both flops reset to 1. Falling edge = synchronised value 0 while previous synchronised value was 1.
- Bit counter: 0..CLKS_PER_BIT-1, wraps. It is forced to 0 on any falling edge in IDLE or RUN (hard sync). The sample strobe fires when count == SAMPLE_POINT.
- States:
  - IDLE_WAIT (reset state): free-running counter. Each recessive sample increments the recessive count; each dominant sample clears it. When the count reaches IDLE_BITS -> IDLE.
  - IDLE: counter held at 0. On a falling edge -> RUN.
  - RUN: described below.
- RUN, first sample (SOF):
  - Dominant: pulse o_Sof, clear o_Stuff_Error, set run length = 1 and last bit = 0. The SOF bit is not emitted on o_Bit_Valid.
  - Recessive (glitch): -> IDLE with no output.
- RUN, later samples with i_Stuff_En = 1:
  - Run length == STUFF_LEN and sample != last bit: stuff bit. Pulse o_Stuff_Bit, no o_Bit_Valid, run length = 1, last bit = sample.
  - Run length == STUFF_LEN and sample == last bit: set o_Stuff_Error, no o_Bit_Valid -> IDLE_WAIT with recessive count = 0.
  - Otherwise: emit the bit. Run length increments if sample == last bit, else resets to 1. Last bit = sample.
- RUN, samples with i_Stuff_En = 0: every sample is emitted and the run-length logic is bypassed. Run length is reset to 1 and last bit is set to the sample, so stuffing can restart cleanly.
- RUN, any sample: a recessive sample increments the recessive count; a dominant sample clears it. When the count reaches IDLE_BITS -> IDLE. This path is reachable only with i_Stuff_En = 0.
- Width rules:
  - Bit counter: clog2(CLKS_PER_BIT) bits.
  - Run counter: clog2(STUFF_LEN+1) bits, saturates at STUFF_LEN.
  - Recessive counter: clog2(IDLE_BITS+1) bits, saturates.

## Timing
- All outputs are registered. Reset values: o_Sof = 0, o_Bit_Valid = 0, o_Bit_Data = 0, o_Stuff_Bit = 0, o_Stuff_Error = 0, o_Bus_Idle = 0. The state is IDLE_WAIT.
- Input to synchronised value: 2 cycles. The edge is detected at cycle E, with counter = 0 at E.
- Sample at E+SAMPLE_POINT. o_Sof, o_Bit_Valid, o_Bit_Data and o_Stuff_Bit are high at E+SAMPLE_POINT+1 for exactly one cycle.
- o_Stuff_Error rises in the same cycle as the corresponding output slot and holds until the cycle after the next o_Sof sample.
- o_Bus_Idle rises one cycle after the IDLE_BITS-th recessive sample. It falls one cycle after the falling edge that enters RUN.
- i_Stuff_En is sampled on the sample-strobe cycle only.
- A falling edge arriving on the same cycle as the sample strobe:
  - The sample is taken first.
  - Then the counter is cleared.
- Reset assertion mid-frame clears all state immediately, regardless of the clock. No pulse may be emitted in the cycle reset is released.

## Test plan
- Power-up and idle:
  - Stimulus: hold reset, release, drive 11 recessive bits.
  - Required: all outputs 0 during reset. o_Bus_Idle = 1 one cycle after the 11th sample.
- Stuff bit removed:
  - Stimulus: from idle, i_Stuff_En = 1, send SOF, 0,0,0,0, 1 (stuff), 1, 0.
  - Required: o_Sof once. o_Bit_Valid ×6 with data 0,0,0,0,1,0. One o_Stuff_Bit pulse, placed between the 4th and 5th data pulses.
- Stuff error and recovery:
  - Stimulus: send SOF followed by 5 dominant bits.
  - Required: 4 data bits of 0, then o_Stuff_Error = 1 with no 5th valid and o_Bus_Idle = 0. After 11 recessive bits, o_Bus_Idle = 1 and o_Stuff_Error stays 1. The next SOF clears o_Stuff_Error.
- Destuff disabled:
  - Stimulus: i_Stuff_En = 0, send SOF, 10 dominant bits, then 11 recessive bits.
  - Required: 10 valid 0 bits, then 11 valid 1 bits, no error, o_Bus_Idle = 1 after the 11th recessive bit.
- Parameter sweep:
  - Stimulus: instances with STUFF_LEN = 3, CLKS_PER_BIT = 16, SAMPLE_POINT = 12. Send SOF, 0, 0, 1 (stuff).
  - Required: 2 data bits, one o_Stuff_Bit pulse. Pulses occur at E+13.
- Mid-frame reset and resync:
  - Stimulus: assert i_Reset_n = 0 after 3 data bits, then release. Separately, shift one falling edge by 3 clocks.
  - Required: after reset, all outputs are 0 and the state is IDLE_WAIT. For the shifted edge, subsequent samples move 3 clocks later and the data is still correct.
